// File: rtl/arb_requester_if.sv
// arb_requester_if: command, arbiter and beat signals of one requester port.
// master drives cmd/flush/grant, slave (the agent) drives req/beat/status.
interface arb_requester_if #(
  parameter int unsigned LEN_W = 4
);
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             flush;
  logic             req;
  logic             grant;
  logic             beat_valid;
  logic [LEN_W-1:0] beat_idx;
  logic             beat_last;
  logic             done;
  logic             preempt;
  logic             starve;

  modport master (
    output cmd_valid, cmd_len, flush, grant,
    input  cmd_ready, req, beat_valid, beat_idx,
    input  beat_last, done, preempt, starve
  );

  modport slave (
    input  cmd_valid, cmd_len, flush, grant,
    output cmd_ready, req, beat_valid, beat_idx,
    output beat_last, done, preempt, starve
  );
endinterface

// File: rtl/arb_requester.sv
// arb_requester: burst requester for one fixed-priority arbiter port.
// Ports: clk, rst_n (async low), bus (slave: cmd/flush/grant in, req/beat/status out).
module arb_requester #(
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned WAIT_W    = 8,
  parameter int unsigned STARVE_TH = 200
) (
  input  logic           clk,
  input  logic           rst_n,
  arb_requester_if.slave bus
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  localparam logic [WAIT_W-1:0] TH = WAIT_W'(STARVE_TH);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              done_q, done_d;
  logic              pre_q, pre_d;
  logic              starve_q, starve_d;
  logic              gprev_q;

  logic active;
  logic beat_v;
  logic beat_l;
  logic rdy;
  logic do_flush;
  logic do_acc;
  logic do_last;
  logic do_beat;
  logic do_wait;

  assign active = (state_q == ACTIVE);
  assign beat_v = active & bus.grant;
  assign beat_l = beat_v & (idx_q == len_q);
  assign rdy    = ~active & ~bus.flush;

  // One-hot event set: flush dominates every
  // other event, accept only exists in IDLE.
  assign do_flush = bus.flush;
  assign do_acc   = rdy & bus.cmd_valid;
  assign do_last  = beat_l & ~bus.flush;
  assign do_beat  = beat_v & ~beat_l & ~bus.flush;
  assign do_wait  = active & ~bus.grant & ~bus.flush;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    pre_d   = 1'b0;
    unique case (1'b1)
      do_flush: begin
        state_d = IDLE;
        req_d   = 1'b0;
        idx_d   = '0;
        wait_d  = '0;
      end
      do_acc: begin
        state_d = ACTIVE;
        req_d   = 1'b1;
        len_d   = bus.cmd_len;
        idx_d   = '0;
        wait_d  = '0;
      end
      do_last: begin
        state_d = IDLE;
        req_d   = 1'b0;
        idx_d   = '0;
        wait_d  = '0;
        done_d  = 1'b1;
      end
      do_beat: begin
        idx_d  = idx_q + LEN_W'(1);
        wait_d = '0;
      end
      do_wait: begin
        if (~&wait_q) wait_d = wait_q + WAIT_W'(1);
        // gprev_q only tracks beats of this burst,
        // so a stale grant seen in IDLE never counts.
        pre_d = gprev_q;
      end
      default: ;
    endcase
    starve_d = (wait_d >= TH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      len_q    <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
      done_q   <= 1'b0;
      pre_q    <= 1'b0;
      starve_q <= 1'b0;
      gprev_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
      pre_q    <= pre_d;
      starve_q <= starve_d;
      gprev_q  <= beat_v;
    end
  end

  assign bus.cmd_ready  = rdy;
  assign bus.req        = req_q;
  assign bus.beat_valid = beat_v;
  assign bus.beat_idx   = idx_q;
  assign bus.beat_last  = beat_l;
  assign bus.done       = done_q;
  assign bus.preempt    = pre_q;
  assign bus.starve     = starve_q;

endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: randomized and directed bursts against a timeline model
// derived from a per-cycle grant pattern.
module tb_arb_requester;
  localparam int LEN_W = 4;
  localparam int WAIT_W = 4;
  localparam int TH = 10;
  localparam int WMAX = (1 << WAIT_W) - 1;
  localparam int NC = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  bit g[NC];

  arb_requester_if #(.LEN_W(LEN_W)) bus ();

  arb_requester #(
    .LEN_W(LEN_W),
    .WAIT_W(WAIT_W),
    .STARVE_TH(TH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  wire [10:0] obs = {bus.req, bus.cmd_ready, bus.beat_valid,
                     bus.beat_idx, bus.beat_last, bus.done,
                     bus.preempt, bus.starve};
  localparam logic [10:0] RST_V = 11'b010_0000_0000;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Cycle 0 presents the command; g[c] is grant in cycle c.
  // fb: beat index carrying flush (-1 none). pd: done expected
  // in cycle 0. chain: stop after the last beat so the next
  // burst is offered in the done cycle.
  task automatic run_burst(input int len, input int fb,
                           input bit pd, input bit chain,
                           input string nm);
    int bc[NC];
    int w[NC+1];
    int nb, L, F, endc, lastc;
    logic e_req, e_rdy, e_bv, e_last, e_done, e_pre, e_st;
    logic act;
    logic [LEN_W-1:0] e_idx;
    nb = 0; L = -1; F = -1;
    for (int c = 0; c < NC; c++) begin
      bc[c] = nb;
      if (c >= 1 && L < 0 && F < 0 && g[c]) begin
        if (nb == fb) F = c;
        nb++;
        if (nb == len + 1) L = c;
      end
    end
    n_tests++;
    if (L < 0 && F < 0) begin
      n_fail++;
      $display("FAIL %s pattern too short got %0d beats need %0d",
               nm, nb, len + 1);
      return;
    end
    endc = (F >= 0) ? F : L;
    w[0] = 0;
    w[1] = 0;
    for (int c = 1; c < NC; c++) begin
      if (c > endc || g[c] || c == F) w[c+1] = 0;
      else w[c+1] = (w[c] + 1 > WMAX) ? WMAX : w[c] + 1;
    end
    lastc = chain ? endc : endc + 2;
    for (int c = 0; c <= lastc; c++) begin
      @(negedge clk);
      bus.cmd_valid = (c == 0);
      if (c == 0) bus.cmd_len = LEN_W'(len);
      bus.grant = g[c];
      bus.flush = (c == F);
      #1;
      act    = (c >= 1 && c <= endc);
      e_req  = act;
      e_rdy  = !act;
      e_bv   = act && g[c];
      e_idx  = act ? LEN_W'(bc[c]) : '0;
      e_last = e_bv && (bc[c] == len);
      e_done = (c == 0) ? pd : (F < 0 && c == L + 1);
      e_pre  = (c >= 3) && (c - 1 <= endc) && g[c-2] &&
               !g[c-1] && (c - 1 != F);
      e_st   = (w[c] >= TH);
      n_tests += 8;
      if (bus.req !== e_req) begin
        n_fail++;
        $display("FAIL %s c%0d req got %0b exp %0b",
                 nm, c, bus.req, e_req);
      end
      if (bus.cmd_ready !== e_rdy) begin
        n_fail++;
        $display("FAIL %s c%0d cmd_ready got %0b exp %0b",
                 nm, c, bus.cmd_ready, e_rdy);
      end
      if (bus.beat_valid !== e_bv) begin
        n_fail++;
        $display("FAIL %s c%0d beat_valid got %0b exp %0b",
                 nm, c, bus.beat_valid, e_bv);
      end
      if (bus.beat_idx !== e_idx) begin
        n_fail++;
        $display("FAIL %s c%0d beat_idx got %0d exp %0d",
                 nm, c, bus.beat_idx, e_idx);
      end
      if (bus.beat_last !== e_last) begin
        n_fail++;
        $display("FAIL %s c%0d beat_last got %0b exp %0b",
                 nm, c, bus.beat_last, e_last);
      end
      if (bus.done !== e_done) begin
        n_fail++;
        $display("FAIL %s c%0d done got %0b exp %0b",
                 nm, c, bus.done, e_done);
      end
      if (bus.preempt !== e_pre) begin
        n_fail++;
        $display("FAIL %s c%0d preempt got %0b exp %0b",
                 nm, c, bus.preempt, e_pre);
      end
      if (bus.starve !== e_st) begin
        n_fail++;
        $display("FAIL %s c%0d starve got %0b exp %0b",
                 nm, c, bus.starve, e_st);
      end
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_len = '0;
    bus.flush = 1'b0;
    bus.grant = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== RST_V) begin
      n_fail++;
      $display("FAIL reset outputs got %b exp %b", obs, RST_V);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int c = 0; c < NC; c++) g[c] = (c >= 2 && c <= 6);
    run_burst(3, -1, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_preempt();
    for (int c = 0; c < NC; c++)
      g[c] = (c == 2 || c == 3 || (c >= 7 && c <= 11));
    run_burst(5, -1, 1'b0, 1'b0, "preempt");
  endtask

  task automatic test_starve();
    for (int c = 0; c < NC; c++) g[c] = (c >= 16);
    run_burst(2, -1, 1'b0, 1'b0, "starve");
  endtask

  task automatic test_saturate();
    for (int c = 0; c < NC; c++) g[c] = (c >= 22);
    run_burst(1, -1, 1'b0, 1'b0, "saturate");
  endtask

  task automatic test_flush();
    for (int c = 0; c < NC; c++) g[c] = (c >= 2);
    run_burst(7, 2, 1'b0, 1'b0, "flush");
    for (int c = 0; c < NC; c++) g[c] = (c >= 2);
    run_burst(0, -1, 1'b0, 1'b0, "after_flush");
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < NC; c++) g[c] = (c >= 2);
    run_burst(0, -1, 1'b0, 1'b1, "b2b_first");
    for (int c = 0; c < NC; c++) g[c] = (c == 0 || c >= 2);
    run_burst(1, -1, 1'b1, 1'b0, "b2b_second");
  endtask

  task automatic test_max_len();
    for (int c = 0; c < NC; c++) g[c] = (c >= 2);
    run_burst(15, -1, 1'b0, 1'b0, "max_len");
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_len = 4'd2;
    bus.flush = 1'b1;
    bus.grant = 1'b0;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle cmd_ready got %0b exp 0",
               bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.flush = 1'b0;
    #1;
    n_tests++;
    if (obs !== RST_V) begin
      n_fail++;
      $display("FAIL flush_idle blocked got %b exp %b", obs, RST_V);
    end
  endtask

  task automatic test_random();
    bit pd;
    bit ch;
    int len, fb, th;
    pd = 1'b0;
    for (int it = 0; it < 24; it++) begin
      len = $urandom_range(0, 15);
      th = $urandom_range(1, 9);
      for (int c = 0; c < NC; c++) begin
        if (c >= 40) g[c] = 1'b1;
        else g[c] = ($urandom_range(0, 9) < th);
      end
      g[1] = 1'b0;
      fb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      ch = (it != 23) && (fb < 0) && ($urandom_range(0, 1) == 1);
      run_burst(len, fb, pd, ch, $sformatf("rand%0d", it));
      pd = ch;
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      bus.cmd_valid = (c == 0);
      bus.cmd_len = 4'd7;
      bus.flush = 1'b0;
      bus.grant = (c >= 2);
    end
    #1;
    n_tests++;
    if (obs !== 11'b101_0011_0000) begin
      n_fail++;
      $display("FAIL reset_mid pre got %b exp %b",
               obs, 11'b101_0011_0000);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== RST_V) begin
      n_fail++;
      $display("FAIL reset_mid async got %b exp %b", obs, RST_V);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.grant = (c == 0);
      #1;
      n_tests++;
      if (obs !== RST_V) begin
        n_fail++;
        $display("FAIL reset_mid after c%0d got %b exp %b",
                 c, obs, RST_V);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_preempt();
    test_starve();
    test_saturate();
    test_flush();
    test_back_to_back();
    test_max_len();
    test_flush_idle();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Requester-side agent for one port of the absolute fixed-priority arbiter.
- Accepts a burst command from a local master and raises req. Waits for the arbiter's registered grant, then issues one beat per granted cycle.
- Tolerates preemption: grant can be revoked at any time, and the burst resumes where it stopped.
- Reports completion, preemption and starvation to the master.

Parameters:
- LEN_W, 4, width of cmd_len; a burst is cmd_len+1 beats (1..2^LEN_W).
- WAIT_W, 8, width of the starvation wait counter.
- STARVE_TH, 200, wait-cycle count at which starve asserts; must be < 2^WAIT_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  master presents a burst command
- cmd_len  in  LEN_W  beats minus one; sampled when cmd_valid & cmd_ready
- cmd_ready  out  1  agent idle, command accepted this cycle if cmd_valid
- flush  in  1  synchronous abort of the current burst
- req  out  1  request to arbiter (registered)
- grant  in  1  this port's grant bit from arbiter (registered there off req)
- beat_valid  out  1  a beat is transferred this cycle
- beat_idx  out  LEN_W  index of the current beat, 0..len
- beat_last  out  1  with beat_valid: final beat of the burst
- done  out  1  one-cycle pulse, cycle after last beat
- preempt  out  1  one-cycle pulse: grant lost with beats remaining
- starve  out  1  level: wait counter >= STARVE_TH

Behaviour:
- States: IDLE, ACTIVE.
- Reset (async, rst_n=0):
  - state=IDLE, req=0, cmd_ready=1.
  - len_q=0, beat_idx=0, wait_cnt=0.
  - done=0, preempt=0, starve=0.
- IDLE:
  - cmd_ready=1, req=0. grant is ignored, so the stale grant that lingers one cycle after req drops is discarded.
  - cmd_valid=1 -> latch len_q=cmd_len, beat_idx=0, wait_cnt=0, state=ACTIVE, req=1 next cycle.
- ACTIVE:
  - cmd_ready=0, req=1.
  - beat_valid = grant (combinational from grant and state). beat_last = beat_valid & (beat_idx==len_q).
  - On beat_valid & ~beat_last: beat_idx+1.
  - On beat_last: state=IDLE, req=0 and done=1 in the next cycle, beat_idx cleared.
- Latency:
  - Command accepted at t -> req=1 at t+1 -> earliest first beat at t+2 (arbiter register).
  - Single-beat burst uncontested: done at t+3.
- Preemption:
  - Condition: ACTIVE, grant was 1 previous cycle, grant=0 now, burst not finished.
  - Response: preempt=1 for one cycle, beat_idx holds, req stays 1, resume on next grant.
  - No preempt pulse for the grant drop after the last beat, since state is IDLE by then.
- Wait counter:
  - In ACTIVE with grant=0: wait_cnt+1, saturating at all-ones.
  - Cleared on any beat, on entering ACTIVE, and on flush.
  - starve registered = (wait_cnt >= STARVE_TH); deasserts the cycle after the clearing event.
- flush:
  - Highest priority; overrides a beat in the same cycle. That cycle's beat_valid is still reported, but it is not counted and no done is issued.
  - Next cycle: state=IDLE, req=0, beat_idx=0, wait_cnt=0, starve=0, no done.
  - In IDLE, flush blocks command acceptance: cmd_ready=0 while flush=1.
- Back-to-back:
  - After done, cmd_ready=1 in the same cycle as done. The new command is accepted then, and req re-asserts the following cycle.
  - Minimum 1-cycle req low between bursts, which lets the arbiter re-evaluate.
- Width rules:
  - beat_idx is LEN_W bits and never exceeds len_q.
  - len=2^LEN_W-1 is a legal maximum burst.
- Reset mid-burst: everything returns to reset values immediately; no done or preempt is emitted.

Test Plan:
- cmd_len=3 at t, grant mirrors req delayed 1 cycle -> req=1 t+1..t+5; beats idx 0..3 at t+2..t+5; beat_last at t+5; done at t+6; req=0 at t+6.
- cmd_len=5, grant drops after idx 1 for 3 cycles -> preempt pulse once; beat_idx holds 2; resumes 2..5; total beat_valid count=6; one done.
- STARVE_TH=10, grant held 0 for 15 cycles after req -> starve=1 from the cycle wait_cnt reaches 10; first grant clears starve next cycle; burst completes normally.
- flush asserted on beat idx 2 of a len=7 burst -> req=0 next cycle, no done, cmd_ready=1 after flush drops; a new cmd_len=0 completes with done.
- Two commands back-to-back (len=0, then len=1), grant always follows req -> stale grant cycle after first burst gives no beat_valid; req low exactly 1 cycle; second burst gives beats 0,1.
- rst_n pulsed low mid-burst (idx 3 of len=7) -> all outputs 0 and cmd_ready=1 asynchronously; no done or preempt after release.
